// File: rtl/regfile_sync_clr.sv
// regfile_sync_clr
//   General-purpose register file for the single-cycle core: two combinational
//   read ports (A, B) and one rising-edge write port (D). After a synchronous
//   reset the whole array is cleared one entry per cycle. busy is asserted for
//   the whole sweep, and the core must stall while it is high.
//
//   Optional feature, selected by the macro REGFILE_BYPASS_EN:
//     defined   - a write accepted this cycle is forwarded to any read port
//                 whose address matches the write address, in the same cycle.
//     undefined - reads show the pre-write contents until the next edge.
//
//   State table
//     state    | meaning
//     ST_CLEAR | clear sweep running (or rst held); writes ignored, reads 0
//     ST_RUN   | normal operation; reads and writes enabled
module regfile_sync_clr #(
   parameter int DWIDTH   = 32,
   parameter int NREGS    = 32,
   parameter int AWIDTH   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [AWIDTH-1:0] Addr_A,
   input  logic [AWIDTH-1:0] Addr_B,
   input  logic [AWIDTH-1:0] Addr_D,
   input  logic [DWIDTH-1:0] Data_D,
   output logic [DWIDTH-1:0] Data_A,
   output logic [DWIDTH-1:0] Data_B,
   output logic              busy
);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Number of registers and last sweep index, expressed at the widths used
   // in the address compares.
   localparam logic [AWIDTH:0]   LP_NREGS = NREGS[AWIDTH:0];
   localparam logic [AWIDTH-1:0] LP_LAST  = AWIDTH'(NREGS - 1);
   localparam logic              LP_ZERO  = (ZERO_REG != 0);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [AWIDTH-1:0]   r_clr_ptr;
   logic [AWIDTH-1:0]   w_clr_ptr_nxt;
   logic                w_clr_en;
   logic [DWIDTH-1:0]   r_mem [NREGS];

   logic                w_busy;
   logic                w_wr_ok;
   logic                w_rd_a_ok;
   logic                w_rd_b_ok;

   // An address is readable or writable only if it lies inside the array and
   // is not the hardwired zero register.
   function automatic logic addr_usable(input logic [AWIDTH-1:0] addr);
      logic in_range;
      logic is_zero;
      in_range = ({1'b0, addr} < LP_NREGS);
      is_zero  = LP_ZERO && (addr == '0);
      return in_range && !is_zero;
   endfunction

   assign w_busy    = (r_state == ST_CLEAR);
   assign busy      = w_busy;
   assign w_wr_ok   = !w_busy && wr && addr_usable(Addr_D);
   assign w_rd_a_ok = !w_busy && addr_usable(Addr_A);
   assign w_rd_b_ok = !w_busy && addr_usable(Addr_B);

   // State register and sweep pointer; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_CLEAR;
         r_clr_ptr <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_ptr <= w_clr_ptr_nxt;
      end
   end

   // Next-state logic: step through the array once, then settle in RUN.
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_ptr_nxt = r_clr_ptr;
      w_clr_en      = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            w_clr_en = !rst;
            if (r_clr_ptr == LP_LAST) begin
               // Hold the pointer on the last entry rather than letting it
               // wrap when NREGS fills the whole address space.
               w_state_nxt = ST_RUN;
            end else begin
               w_clr_ptr_nxt = r_clr_ptr + 1'b1;
            end
         end
         ST_RUN: begin
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_CLEAR;
         end
      endcase
   end

   // Storage array: the sweep clear takes priority; otherwise an accepted write.
   always_ff @(posedge clk) begin
      if (w_clr_en) begin
         r_mem[r_clr_ptr] <= '0;
      end else if (w_wr_ok) begin
         r_mem[Addr_D] <= Data_D;
      end
   end

   // Read port A: zero while busy, out of range, or on the zero register.
   always_comb begin
      Data_A = '0;
      if (w_rd_a_ok) begin
         Data_A = r_mem[Addr_A];
`ifdef REGFILE_BYPASS_EN
         if (w_wr_ok && (Addr_A == Addr_D)) begin
            Data_A = Data_D;
         end
`endif
      end
   end

   // Read port B: same rules as port A and independent of it.
   always_comb begin
      Data_B = '0;
      if (w_rd_b_ok) begin
         Data_B = r_mem[Addr_B];
`ifdef REGFILE_BYPASS_EN
         if (w_wr_ok && (Addr_B == Addr_D)) begin
            Data_B = Data_D;
         end
`endif
      end
   end

endmodule
